// File: rtl/range_sum_pkg.sv
// Shared state encoding and helpers for the range_sum controller and datapath.
// Overflow handling is selected by the RANGE_SUM_OVF_EN macro.
package range_sum_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_ACCUM = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        LOAD  = ST_LOAD,
        ACCUM = ST_ACCUM,
        DONE  = ST_DONE
    } state_e;

    // Adder width wide enough that neither the sum nor the counter operand can drop a carry.
    function automatic int sum_width(input int w, input int cw);
        return ((w > cw + 1) ? w : cw + 1) + 1;
    endfunction

endpackage

// File: rtl/range_sum_datapath.sv
// Counter, sum register, term comparator and adder for range_sum.
// RANGE_SUM_OVF_EN adds a carry-detecting adder, a sticky overflow flag and result saturation.
module range_sum_datapath
    import range_sum_pkg::*;
#(
    parameter int W  = 32,
    parameter int CW = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_ld,
    input  logic          i_en,
    input  logic [CW-1:0] i_lo,
    input  logic [CW-1:0] i_hi,
    input  logic [CW-1:0] i_step,
    output logic          o_term_gt_hi,
    output logic [W-1:0]  o_result,
    output logic          o_overflow
);

    // One extra bit so counter+step can never wrap back below hi.
    logic [CW:0]  r_counter;
    logic [W-1:0] r_sum;
    logic [W-1:0] w_sum_next;
    logic         w_term_gt_hi;

    assign w_term_gt_hi = (r_counter > {1'b0, i_hi});
    assign o_term_gt_hi = w_term_gt_hi;

`ifdef RANGE_SUM_OVF_EN
    localparam int SW = sum_width(W, CW);

    logic [SW-1:0] w_add;
    logic          w_carry;
    logic          r_ovf;

    assign w_add      = SW'(r_sum) + SW'(r_counter);
    assign w_carry    = |w_add[SW-1:W];
    assign w_sum_next = w_add[W-1:0];
    assign o_result   = r_ovf ? '1 : r_sum;
    assign o_overflow = r_ovf;
`else
    assign w_sum_next = r_sum + W'(r_counter);
    assign o_result   = r_sum;
    assign o_overflow = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_counter <= '0;
            r_sum     <= '0;
`ifdef RANGE_SUM_OVF_EN
            r_ovf     <= 1'b0;
`endif
        end else if (i_ld) begin
            r_counter <= {1'b0, i_lo};
            r_sum     <= '0;
`ifdef RANGE_SUM_OVF_EN
            r_ovf     <= 1'b0;
`endif
        end else if (i_en && !w_term_gt_hi) begin
            r_sum     <= w_sum_next;
            r_counter <= r_counter + {1'b0, i_step};
`ifdef RANGE_SUM_OVF_EN
            if (w_carry) begin
                r_ovf <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: rtl/range_sum.sv
// Arithmetic-series summation controller: sums lo, lo+step, ... up to hi.
// Build with RANGE_SUM_OVF_EN for overflow detection and saturation; default wraps.
//
// state | meaning
// IDLE  | post-reset, waiting for start, result shows 0
// LOAD  | operands captured, datapath loads counter=lo and clears sum
// ACCUM | adds one term per cycle until the counter passes hi
// DONE  | result valid, finish high; start here restarts immediately
module range_sum
    import range_sum_pkg::*;
#(
    parameter int W  = 32,
    parameter int CW = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [CW-1:0] i_lo,
    input  logic [CW-1:0] i_hi,
    input  logic [CW-1:0] i_step,
    output logic [W-1:0]  o_result,
    output logic          o_finish,
    output logic          o_busy,
    output logic          o_overflow
);

    state_e        r_state;
    logic [CW-1:0] r_lo;
    logic [CW-1:0] r_hi;
    logic [CW-1:0] r_step;
    logic          r_finish;
    logic          r_busy;

    logic          w_ld;
    logic          w_en;
    logic          w_term_gt_hi;

    assign w_ld = (r_state == LOAD);
    assign w_en = (r_state == ACCUM);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_lo     <= '0;
            r_hi     <= '0;
            r_step   <= '0;
            r_finish <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (i_start) begin
                        r_lo     <= i_lo;
                        r_hi     <= i_hi;
                        // A zero step would never terminate; treat it as one.
                        r_step   <= (i_step == '0) ? CW'(1) : i_step;
                        r_state  <= LOAD;
                        r_finish <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                LOAD: begin
                    r_state <= ACCUM;
                end
                ACCUM: begin
                    if (w_term_gt_hi) begin
                        r_state  <= DONE;
                        r_finish <= 1'b1;
                        r_busy   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    range_sum_datapath #(
        .W  (W),
        .CW (CW)
    ) u_datapath (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_ld         (w_ld),
        .i_en         (w_en),
        .i_lo         (r_lo),
        .i_hi         (r_hi),
        .i_step       (r_step),
        .o_term_gt_hi (w_term_gt_hi),
        .o_result     (o_result),
        .o_overflow   (o_overflow)
    );

    assign o_finish = r_finish;
    assign o_busy   = r_busy;

endmodule

// File: tb/tb_range_sum.sv
// Self-checking bench for range_sum: two instances (W=13 and W=8) share stimulus and
// are compared against a closed-form arithmetic-series model.
module tb_range_sum;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] lo;
    logic [15:0] hi;
    logic [15:0] step;

    logic [12:0] res_a;
    logic        fin_a, busy_a, ovf_a;
    logic [7:0]  res_b;
    logic        fin_b, busy_b, ovf_b;

    int total = 0;
    int bad   = 0;
    logic [63:0] last_a;
    logic [63:0] last_b;

    always #5 clk = ~clk;

    range_sum #(.W(13), .CW(16)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_lo(lo), .i_hi(hi), .i_step(step),
        .o_result(res_a), .o_finish(fin_a), .o_busy(busy_a), .o_overflow(ovf_a)
    );

    range_sum #(.W(8), .CW(16)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_lo(lo), .i_hi(hi), .i_step(step),
        .o_result(res_b), .o_finish(fin_b), .o_busy(busy_b), .o_overflow(ovf_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint model_n(input longint l, input longint h, input longint s);
        longint se = (s == 0) ? 1 : s;
        if (l > h) return 0;
        return (h - l) / se + 1;
    endfunction

    function automatic longint model_sum(input longint l, input longint h, input longint s);
        longint se = (s == 0) ? 1 : s;
        longint n  = model_n(l, h, s);
        return n * l + se * n * (n - 1) / 2;
    endfunction

    function automatic logic [63:0] exp_res(input longint sum, input int w);
        longint lim = longint'(1) << w;
`ifdef RANGE_SUM_OVF_EN
        if (sum >= lim) return 64'(lim - 1);
`endif
        return 64'(sum % lim);
    endfunction

    function automatic logic [63:0] exp_ovf(input longint sum, input int w);
`ifdef RANGE_SUM_OVF_EN
        return (sum >= (longint'(1) << w)) ? 64'd1 : 64'd0;
`else
        if (sum < 0 || w < 0) return 64'd1;
        return 64'd0;
`endif
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_res_a"},  64'(res_a),  64'd0);
        check({tag, "_fin_a"},  64'(fin_a),  64'd0);
        check({tag, "_busy_a"}, 64'(busy_a), 64'd0);
        check({tag, "_ovf_a"},  64'(ovf_a),  64'd0);
        check({tag, "_res_b"},  64'(res_b),  64'd0);
        check({tag, "_fin_b"},  64'(fin_b),  64'd0);
        check({tag, "_busy_b"}, 64'(busy_b), 64'd0);
        check({tag, "_ovf_b"},  64'(ovf_b),  64'd0);
    endtask

    // Starts a run on the next edge; with jitter, inputs and start toggle while busy.
    task automatic run(input string tag, input logic [15:0] l, input logic [15:0] h,
                       input logic [15:0] s, input bit jitter);
        longint n   = model_n(longint'(l), longint'(h), longint'(s));
        longint sum = model_sum(longint'(l), longint'(h), longint'(s));
        int     lat = 0;
        bit     busy_ok = 1'b1;
        @(negedge clk);
        lo = l; hi = h; step = s; start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 4000; k++) begin
            @(negedge clk);
            if (jitter) begin
                lo    = 16'($urandom);
                hi    = 16'($urandom);
                step  = 16'($urandom);
                start = (longint'(k) <= n + 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (fin_a) begin
                lat = k;
                break;
            end
            if (!busy_a || !busy_b || fin_b) busy_ok = 1'b0;
        end
        check({tag, "_latency"}, 64'(lat), 64'(n + 2));
        check({tag, "_busy_during"}, 64'(busy_ok), 64'd1);
        check({tag, "_busy_done"}, 64'(busy_a), 64'd0);
        check({tag, "_fin_b"}, 64'(fin_b), 64'd1);
        check({tag, "_res_a"}, 64'(res_a), exp_res(sum, 13));
        check({tag, "_ovf_a"}, 64'(ovf_a), exp_ovf(sum, 13));
        check({tag, "_res_b"}, 64'(res_b), exp_res(sum, 8));
        check({tag, "_ovf_b"}, 64'(ovf_b), exp_ovf(sum, 8));
        last_a = exp_res(sum, 13);
        last_b = exp_res(sum, 8);
    endtask

    // Idle cycles in DONE with changing inputs; result must hold.
    task automatic idle_hold(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            start = 1'b0;
            lo    = 16'($urandom);
            hi    = 16'($urandom);
            step  = 16'($urandom);
        end
        @(posedge clk);
        #1;
        check({tag, "_hold_fin"},   64'(fin_a), 64'd1);
        check({tag, "_hold_res_a"}, 64'(res_a), last_a);
        check({tag, "_hold_res_b"}, 64'(res_b), last_b);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; lo = '0; hi = '0; step = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_res", 64'(res_a), 64'd0);

        run("sum_1_100",   16'd1,  16'd100, 16'd1, 1'b0);
        run("b2b_3_20_4",  16'd3,  16'd20,  16'd4, 1'b0);
        idle_hold("after_55", 3);
        run("lo_gt_hi",    16'd10, 16'd5,   16'd7, 1'b0);
        run("step_zero",   16'd1,  16'd4,   16'd0, 1'b0);
        idle_hold("after_10", 2);
        run("top_edge",    16'hFFFF, 16'hFFFF, 16'd1, 1'b0);
        run("big_step",    16'd65530, 16'hFFFF, 16'hFFFF, 1'b0);
        run("jitter_1_100", 16'd1, 16'd100, 16'd1, 1'b1);

        // Abort mid-ACCUM; start during reset must be ignored.
        @(negedge clk);
        lo = 16'd1; hi = 16'd200; step = 16'd1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("abort");
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        check("abort_start_ignored", 64'(busy_a), 64'd0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(posedge clk);
        #1;
        check("abort_idle_res", 64'(res_a), 64'd0);
        run("after_abort", 16'd1, 16'd10, 16'd1, 1'b0);

        for (int r = 0; r < 40; r++) begin
            logic [15:0] l, h, s;
            l = 16'($urandom_range(0, 300));
            h = 16'($urandom_range(0, 300));
            s = 16'($urandom_range(0, 20));
            if ($urandom_range(0, 7) == 0) begin
                l = 16'($urandom_range(60000, 65535));
                h = 16'hFFFF;
                s = 16'($urandom_range(0, 2000));
            end
            run($sformatf("rand%0d", r), l, h, s, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle_hold($sformatf("rand%0d", r), $urandom_range(1, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/range_sum.md
RANGE_SUM -- requirements
Module: range_sum

Interface
REQ-001 Parameter W, default 32: result width in bits.
REQ-002 Parameter CW, default 16: width of the lo/hi/step operands.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to begin a summation; sampled on the rising edge.
REQ-006 lo  input  CW  first term, unsigned.
REQ-007 hi  input  CW  inclusive upper bound, unsigned.
REQ-008 step  input  CW  term increment, unsigned; value 0 is treated as 1.
REQ-009 result  output  W  sum of lo, lo+step, ... while term <= hi; valid while finish=1.
REQ-010 finish  output  1  high while result is valid.
REQ-011 busy  output  1  high while a summation is in progress (LOAD or ACCUM).
REQ-012 overflow  output  1  sticky overflow flag for the current result.

Function
REQ-013 The FSM SHALL have four states: IDLE, LOAD, ACCUM, DONE.
REQ-014 IDLE, or DONE, with start=1 SHALL capture lo/hi/step into registers and go to LOAD; finish SHALL drop on that edge.
REQ-015 start asserted in LOAD or ACCUM SHALL be ignored.
REQ-016 LOAD SHALL clear sum and overflow, set counter=lo, and go to ACCUM.
REQ-017 In ACCUM, counter<=hi SHALL add counter to sum and add step to counter in the same cycle; counter>hi SHALL go to DONE.
REQ-018 The counter SHALL be CW+1 bits wide, so counter+step never wraps and the loop always terminates.
REQ-019 Input changes after capture SHALL have no effect on the current run.
REQ-020 With n = number of terms, finish SHALL be high n+2 cycles after the edge that samples start.
REQ-021 lo>hi SHALL give n=0, result=0, and finish 2 cycles after start.
REQ-022 In DONE, finish=1 and busy=0; result and overflow SHALL hold until the next accepted start or reset.
REQ-023 In IDLE, LOAD and ACCUM, finish SHALL be 0.
REQ-024 In IDLE, result SHALL show 0. In LOAD and ACCUM, it SHALL show the running sum and is not valid.

Reset
REQ-025 rst=1 SHALL force IDLE at the next edge, from any state, including mid-ACCUM.
REQ-026 Reset SHALL clear result, finish, busy, overflow and all internal registers to 0.
REQ-027 While rst=1, start SHALL be ignored.

Configuration
REQ-028 Macro RANGE_SUM_OVF_EN SHALL select overflow handling.
REQ-029 When RANGE_SUM_OVF_EN is defined:
- the sum SHALL use a W+1-bit adder;
- a carry out SHALL set overflow, which stays set until LOAD;
- result SHALL saturate to all ones from then until LOAD.
REQ-030 When RANGE_SUM_OVF_EN is not defined:
- the sum SHALL wrap modulo 2^W;
- overflow SHALL be tied to 0.

Structure
REQ-031 Package range_sum_pkg SHALL hold the FSM state enum and the state encoding constants.
REQ-032 Control SHALL be the FSM in range_sum. Counter, sum register, comparator and adder SHALL be one sub-module, range_sum_datapath.
REQ-033 The FSM SHALL drive the datapath with ld and en strobes only. The datapath SHALL return a single term_gt_hi status.

Verification
REQ-034 W=13, lo=1, hi=100, step=1, start pulse -> finish after 102 cycles, result=5050, overflow=0.
REQ-035 lo=3, hi=20, step=4 -> terms 3,7,11,15,19; result=55; finish after 7 cycles.
REQ-036 lo=10, hi=5 -> result=0, finish after 2 cycles; also step=0, lo=1, hi=4 -> result=10.
REQ-037 W=8, lo=1, hi=100, step=1 with the macro defined -> overflow=1, result=255. Without the macro -> overflow=0, result=5050 mod 256=186.
REQ-038 rst pulsed mid-ACCUM, then a new start with lo=1, hi=10 -> cycle after reset: all outputs 0; result=55 with no residue from the aborted run.
REQ-039 Extra start pulses during busy are ignored. start held high in DONE -> back-to-back restart, finish low for exactly n+2 cycles.
